// File: rtl/vga_pkg.sv
// Shared VGA timing constants and sync-state encodings.
// Both the timing generator and the downstream color mapper import this package.
package vga_pkg;

    localparam int CNT_W = 10;

    // 640x480 @ 60 Hz timing with a 25 MHz pixel rate, derived from the 50 MHz system clock.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        H_ACT = 2'd0,
        H_FP  = 2'd1,
        H_SYN = 2'd2,
        H_BP  = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACT = 2'd0,
        V_FP  = 2'd1,
        V_SYN = 2'd2,
        V_BP  = 2'd3
    } v_state_t;

endpackage

// File: rtl/sync_stage_counter.sv
// Mod-N up counter with enable.
// o_count_next and o_wrap are combinational look-ahead signals, so the parent
// can register decoded outputs in step with the count itself.
module sync_stage_counter
    import vga_pkg::*;
#(
    parameter int N = DEF_H_TOTAL
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Next count: hold, wrap at N-1, or increment.
    always_comb begin
        o_wrap = i_en & (r_count == LAST);
        if (!i_en) begin
            o_count_next = r_count;
        end else if (o_wrap) begin
            o_count_next = ZERO;
        end else begin
            o_count_next = r_count + ONE;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= ZERO;
        end else begin
            r_count <= o_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A pixel step happens every second Clk. The horizontal counter wraps each line,
// and the vertical counter is stepped by that wrap. Sync and blank are registered
// from the look-ahead count and state, so they line up with DrawX/DrawY.
// The first pixel step after reset presents pixel 0/0 instead of advancing past it;
// that step starts frame 0, turning on blank and pulsing frame_start.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       run,
    output logic       pixel_clk,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_FP_START  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYN_START = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] H_BP_START  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_FP_START  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYN_START = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] V_BP_START  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    logic             r_pix_en;
    logic             r_primed;
    logic             w_step;
    logic             w_adv;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_frame_start_next;
    logic [CNT_W-1:0] w_x;
    logic [CNT_W-1:0] w_x_next;
    logic [CNT_W-1:0] w_y;
    logic [CNT_W-1:0] w_y_next;
    h_state_t         r_h_state;
    h_state_t         w_h_state_next;
    v_state_t         r_v_state;
    v_state_t         w_v_state_next;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank;
    logic             r_frame_start;
    logic [7:0]       r_frame_cnt;

    // Pixel-enable divider: toggles every Clk while running, frozen otherwise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pix_en <= 1'b0;
        end else if (run) begin
            r_pix_en <= ~r_pix_en;
        end else begin
            r_pix_en <= r_pix_en;
        end
    end

    assign w_step = run & r_pix_en;
    assign w_adv  = w_step & r_primed;

    sync_stage_counter #(
        .N (H_TOTAL)
    ) u_h_cnt (
        .i_clk        (Clk),
        .i_rst_n      (Reset_n),
        .i_en         (w_adv),
        .o_count      (w_x),
        .o_count_next (w_x_next),
        .o_wrap       (w_h_wrap)
    );

    sync_stage_counter #(
        .N (V_TOTAL)
    ) u_v_cnt (
        .i_clk        (Clk),
        .i_rst_n      (Reset_n),
        .i_en         (w_h_wrap),
        .o_count      (w_y),
        .o_count_next (w_y_next),
        .o_wrap       (w_v_wrap)
    );

    // Horizontal next state, decoded from the count the line is about to show.
    always_comb begin
        w_h_state_next = r_h_state;
        if (w_adv) begin
            case (r_h_state)
                H_ACT: if (w_x_next == H_FP_START) w_h_state_next = H_FP;  else w_h_state_next = H_ACT;
                H_FP:  if (w_x_next == H_SYN_START) w_h_state_next = H_SYN; else w_h_state_next = H_FP;
                H_SYN: if (w_x_next == H_BP_START) w_h_state_next = H_BP;  else w_h_state_next = H_SYN;
                H_BP:  if (w_x_next == CNT_ZERO) w_h_state_next = H_ACT;   else w_h_state_next = H_BP;
                default: w_h_state_next = H_ACT;
            endcase
        end else begin
            w_h_state_next = r_h_state;
        end
    end

    // Vertical next state; it can only move on a line wrap.
    always_comb begin
        w_v_state_next = r_v_state;
        if (w_h_wrap) begin
            case (r_v_state)
                V_ACT: if (w_y_next == V_FP_START) w_v_state_next = V_FP;  else w_v_state_next = V_ACT;
                V_FP:  if (w_y_next == V_SYN_START) w_v_state_next = V_SYN; else w_v_state_next = V_FP;
                V_SYN: if (w_y_next == V_BP_START) w_v_state_next = V_BP;  else w_v_state_next = V_SYN;
                V_BP:  if (w_y_next == CNT_ZERO) w_v_state_next = V_ACT;   else w_v_state_next = V_BP;
                default: w_v_state_next = V_ACT;
            endcase
        end else begin
            w_v_state_next = r_v_state;
        end
    end

    // State registers for both sync FSMs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_h_state <= H_ACT;
            r_v_state <= V_ACT;
        end else begin
            r_h_state <= w_h_state_next;
            r_v_state <= w_v_state_next;
        end
    end

    // A frame begins on the priming step or when the raster wraps back to 0/0.
    assign w_frame_start_next = w_step & (~r_primed | w_v_wrap);

    // Registered sync, blank and frame outputs, updated only on pixel steps.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_primed      <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else if (!run) begin
            r_frame_start <= 1'b0;
        end else if (w_step) begin
            r_primed      <= 1'b1;
            r_hs          <= (w_h_state_next != H_SYN);
            r_vs          <= (w_v_state_next != V_SYN);
            r_blank       <= (w_h_state_next == H_ACT) && (w_v_state_next == V_ACT);
            r_frame_start <= w_frame_start_next;
            if (w_frame_start_next) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign pixel_clk   = r_pix_en;
    assign DrawX       = w_x;
    assign DrawY       = w_y;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-timing instance and a default 640x480 instance.
// Both are checked every Clk against a raster model built from the pixel-step count.
module tb_vga_timing_gen;

    localparam int S_HA = 6;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 2;
    localparam int S_VA = 4;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 2;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;
    localparam logic [32:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       run = 1'b0;
    logic       pclk0, hs0, vs0, blank0, fs0;
    logic [9:0] x0, y0;
    logic [7:0] fc0;
    logic       pclk1, hs1, vs1, blank1, fs1;
    logic [9:0] x1, y1;
    logic [7:0] fc1;

    int HA[2] = '{S_HA, 640};
    int HF[2] = '{S_HF, 16};
    int HS[2] = '{S_HS, 96};
    int HB[2] = '{S_HB, 48};
    int VA[2] = '{S_VA, 480};
    int VF[2] = '{S_VF, 10};
    int VS[2] = '{S_VS, 2};
    int VB[2] = '{S_VB, 33};

    bit m_pe[2];
    bit m_primed[2];
    bit m_fs[2];
    bit m_step[2];
    int m_adv[2];
    int m_frames[2];

    int checks = 0;
    int failures = 0;
    int found, hs_low, vs_low, vs_bad, wraps, fs_seen, blank_steps, blank_bad, fc_start;
    logic [9:0]  prev_x;
    logic [32:0] freeze_exp;

    always #10 Clk = ~Clk;

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
    ) dut_small (
        .Clk (Clk), .Reset_n (Reset_n), .run (run), .pixel_clk (pclk0),
        .DrawX (x0), .DrawY (y0), .hs (hs0), .vs (vs0), .blank (blank0),
        .frame_start (fs0), .frame_cnt (fc0)
    );

    vga_timing_gen dut_def (
        .Clk (Clk), .Reset_n (Reset_n), .run (run), .pixel_clk (pclk1),
        .DrawX (x1), .DrawY (y1), .hs (hs1), .vs (vs1), .blank (blank1),
        .frame_start (fs1), .frame_cnt (fc1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            if (failures <= 20) $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pe[d] = 1'b0; m_primed[d] = 1'b0; m_fs[d] = 1'b0; m_step[d] = 1'b0;
            m_adv[d] = 0; m_frames[d] = 0;
        end
    endtask

    // One Clk edge of the raster model, using the run level held across the edge.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int ft;
            ft = (HA[d] + HF[d] + HS[d] + HB[d]) * (VA[d] + VF[d] + VS[d] + VB[d]);
            m_fs[d] = 1'b0;
            m_step[d] = 1'b0;
            if (run) begin
                if (m_pe[d]) begin
                    m_step[d] = 1'b1;
                    if (!m_primed[d]) begin
                        m_primed[d] = 1'b1;
                        m_fs[d] = 1'b1;
                        m_frames[d]++;
                    end else begin
                        m_adv[d]++;
                        if (m_adv[d] % ft == 0) begin
                            m_fs[d] = 1'b1;
                            m_frames[d]++;
                        end
                    end
                end
                m_pe[d] = !m_pe[d];
            end
        end
    endtask

    function automatic logic [32:0] exp_vec(input int d);
        int ht, vt, x, y, fr;
        logic h, v, b;
        ht = HA[d] + HF[d] + HS[d] + HB[d];
        vt = VA[d] + VF[d] + VS[d] + VB[d];
        x = m_adv[d] % ht;
        y = (m_adv[d] / ht) % vt;
        fr = m_frames[d];
        h = !((x >= HA[d] + HF[d]) && (x < HA[d] + HF[d] + HS[d]));
        v = !((y >= VA[d] + VF[d]) && (y < VA[d] + VF[d] + VS[d]));
        b = m_primed[d] && (x < HA[d]) && (y < VA[d]);
        return {m_pe[d], x[9:0], y[9:0], h, v, b, m_fs[d], fr[7:0]};
    endfunction

    function automatic logic [32:0] dut_vec(input int d);
        if (d == 0) return {pclk0, x0, y0, hs0, vs0, blank0, fs0, fc0};
        else        return {pclk1, x1, y1, hs1, vs1, blank1, fs1, fc1};
    endfunction

    task automatic tick();
        @(posedge Clk);
        if (Reset_n) model_edge(); else model_reset();
        #1;
        check("cycle_small", 64'(dut_vec(0)), 64'(exp_vec(0)));
        check("cycle_default", 64'(dut_vec(1)), 64'(exp_vec(1)));
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("reset_small", 64'(dut_vec(0)), 64'(RESET_VEC));
        check("reset_default", 64'(dut_vec(1)), 64'(RESET_VEC));

        // Release, prime, then one full default line
        Reset_n = 1'b1;
        run = 1'b1;
        tick();
        tick();
        check("prime_fs", 64'(fs1), 64'd1);
        check("prime_blank", 64'(blank1), 64'd1);
        check("prime_cnt", 64'(fc1), 64'd1);
        hs_low = 0; wraps = 0; prev_x = x1;
        repeat (1600) begin
            tick();
            if (!hs1) hs_low++;
            if (prev_x == 10'd799 && x1 == 10'd0) wraps++;
            prev_x = x1;
        end
        check("line_wraps", 64'(wraps), 64'd1);
        check("line_x", 64'(x1), 64'd0);
        check("line_y", 64'(y1), 64'd1);
        check("hs_low_clk", 64'(hs_low), 64'd192);

        // One full reduced frame from a frame_start
        found = 0;
        for (int i = 0; i < 4 * S_FT && found == 0; i++) begin
            tick();
            if (fs0) found = 1;
        end
        check("wait_frame", 64'(found), 64'd1);
        fc_start = int'(fc0);
        vs_low = 0; vs_bad = 0; fs_seen = 0; blank_steps = 0; blank_bad = 0;
        repeat (2 * S_FT) begin
            tick();
            if (!vs0) vs_low++;
            if (!vs0 && (y0 < 10'(S_VA + S_VF) || y0 >= 10'(S_VA + S_VF + S_VS))) vs_bad++;
            if (fs0) fs_seen++;
            if (m_step[0] && blank0) blank_steps++;
            if (blank0 && (x0 >= 10'(S_HA) || y0 >= 10'(S_VA))) blank_bad++;
        end
        check("frame_vs_low", 64'(vs_low), 64'(S_VS * S_HT * 2));
        check("frame_vs_rows", 64'(vs_bad), 64'd0);
        check("frame_fs_once", 64'(fs_seen), 64'd1);
        check("frame_cnt_inc", 64'(fc0), 64'((fc_start + 1) % 256));
        check("frame_blank_steps", 64'(blank_steps), 64'(S_HA * S_VA));
        check("frame_blank_area", 64'(blank_bad), 64'd0);

        // Freeze for 37 Clk on the last front-porch pixel
        found = 0;
        for (int i = 0; i < 4 * S_FT && found == 0; i++) begin
            tick();
            if (m_step[0] && x0 == 10'(S_HA + S_HF - 1)) found = 1;
        end
        check("wait_fp_end", 64'(found), 64'd1);
        run = 1'b0;
        freeze_exp = exp_vec(0);
        repeat (37) begin
            tick();
            check("freeze", 64'(dut_vec(0)), 64'(freeze_exp));
        end
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 4 && found == 0; i++) begin
            tick();
            if (m_step[0]) found = 1;
        end
        check("resume_step", 64'(found), 64'd1);
        check("resume_x", 64'(x0), 64'(S_HA + S_HF));
        check("resume_hs", 64'(hs0), 64'd0);

        // Randomised run gating
        repeat (400) begin
            run = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset in mid-frame
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 8 * S_FT && found == 0; i++) begin
            tick();
            if (m_step[0] && y0 == 10'd2 && x0 == 10'd4) found = 1;
        end
        check("wait_midframe", 64'(found), 64'd1);
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_small", 64'(dut_vec(0)), 64'(RESET_VEC));
        check("async_reset_default", 64'(dut_vec(1)), 64'(RESET_VEC));
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        check("reprime_fs", 64'(fs0), 64'd1);
        check("reprime_blank", 64'(blank0), 64'd1);
        check("reprime_cnt", 64'(fc0), 64'd1);

        // 256 frames: the counter wraps on the 256th frame_start
        fs_seen = 1;
        found = 0;
        for (int i = 0; i < 256 * 2 * S_FT + 100 && found == 0; i++) begin
            tick();
            if (fs0) begin
                fs_seen++;
                if (fs_seen == 255) check("cnt_255", 64'(fc0), 64'd255);
                if (fs_seen == 256) begin
                    check("cnt_wrap", 64'(fc0), 64'd0);
                    found = 1;
                end
            end
        end
        check("wrap_seen", 64'(found), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
